// File: rtl/mdu_pkg.sv
// Shared definitions for the Small-MIPS multiply/divide unit:
// op codes, FSM state encoding and op-class helpers.
package mdu_pkg;

   localparam logic [2:0] MULT  = 3'b000;
   localparam logic [2:0] MULTU = 3'b001;
   localparam logic [2:0] DIV   = 3'b010;
   localparam logic [2:0] DIVU  = 3'b011;
   localparam logic [2:0] MTHI  = 3'b100;
   localparam logic [2:0] MTLO  = 3'b101;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] CALC = 2'b01;
   localparam logic [1:0] FIX  = 2'b10;

   // MULT/MULTU/DIV/DIVU all have op[2] clear; the signed ones also have op[0] clear.
   function automatic logic isIterOp(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic isSignedOp(input logic [2:0] op);
      return (op[2] == 1'b0) && (op[0] == 1'b0);
   endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate, used both for operand magnitudes
// and for restoring the sign of the final product/quotient/remainder.
module mdu_negate #(
   parameter int WIDTH = 32
) (
   input  logic             en_i,
   input  logic [WIDTH-1:0] val_i,
   output logic [WIDTH-1:0] val_o
);

   assign val_o = en_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply,
// restoring divide, one iteration per cycle, sign fix-up in a final cycle.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_op1,
   input  logic [WIDTH-1:0] i_op2,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_dz,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             isDiv_q, isDiv_d;
   logic             resNeg_q, resNeg_d;
   logic             remNeg_q, remNeg_d;
   logic             divZero_q, divZero_d;
   logic [WIDTH-1:0] accHi_q, accHi_d;
   logic [WIDTH-1:0] accLo_q, accLo_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] op1Raw_q, op1Raw_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;

   logic             signedOp;
   logic [WIDTH-1:0] absOp1, absOp2;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   remShift, remDiff;
   logic [2*WIDTH-1:0] prodFixed;
   logic [WIDTH-1:0] quoFixed, remFixed;

   assign signedOp = isSignedOp(i_op);

   mdu_negate #(.WIDTH(WIDTH)) uAbsOp1 (
      .en_i (signedOp & i_op1[WIDTH-1]),
      .val_i(i_op1),
      .val_o(absOp1)
   );

   mdu_negate #(.WIDTH(WIDTH)) uAbsOp2 (
      .en_i (signedOp & i_op2[WIDTH-1]),
      .val_i(i_op2),
      .val_o(absOp2)
   );

   mdu_negate #(.WIDTH(2*WIDTH)) uFixProd (
      .en_i (resNeg_q),
      .val_i({accHi_q, accLo_q}),
      .val_o(prodFixed)
   );

   mdu_negate #(.WIDTH(WIDTH)) uFixQuo (
      .en_i (resNeg_q),
      .val_i(accLo_q),
      .val_o(quoFixed)
   );

   mdu_negate #(.WIDTH(WIDTH)) uFixRem (
      .en_i (remNeg_q),
      .val_i(accHi_q),
      .val_o(remFixed)
   );

   // Multiply keeps the multiplier in accLo and shifts the partial product in from the top;
   // divide keeps the dividend/quotient in accLo and the remainder in accHi.
   assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
   assign remShift = {accHi_q, accLo_q[WIDTH-1]};
   assign remDiff  = remShift - {1'b0, opB_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      isDiv_d   = isDiv_q;
      resNeg_d  = resNeg_q;
      remNeg_d  = remNeg_q;
      divZero_d = divZero_q;
      accHi_d   = accHi_q;
      accLo_d   = accLo_q;
      opB_d     = opB_q;
      op1Raw_d  = op1Raw_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dz_d      = dz_q;

      case (state_q)
         IDLE: begin
            if (i_start && isIterOp(i_op)) begin
               state_d   = CALC;
               cnt_d     = CNT_W'(WIDTH);
               busy_d    = 1'b1;
               dz_d      = 1'b0;
               isDiv_d   = i_op[1];
               resNeg_d  = signedOp & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
               remNeg_d  = signedOp & i_op1[WIDTH-1];
               divZero_d = i_op[1] && (i_op2 == '0);
               accHi_d   = '0;
               accLo_d   = absOp1;
               opB_d     = absOp2;
               op1Raw_d  = i_op1;
            end else if (i_start && (i_op == MTHI)) begin
               hi_d = i_op1;
            end else if (i_start && (i_op == MTLO)) begin
               lo_d = i_op1;
            end
         end

         CALC: begin
            if (isDiv_q) begin
               if (!remDiff[WIDTH]) begin
                  accHi_d = remDiff[WIDTH-1:0];
                  accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
               end else begin
                  accHi_d = remShift[WIDTH-1:0];
                  accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               accHi_d = mulSum[WIDTH:1];
               accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (isDiv_q && divZero_q) begin
               lo_d = '1;
               hi_d = op1Raw_q;
               dz_d = 1'b1;
            end else if (isDiv_q) begin
               lo_d = quoFixed;
               hi_d = remFixed;
            end else begin
               hi_d = prodFixed[2*WIDTH-1:WIDTH];
               lo_d = prodFixed[WIDTH-1:0];
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         isDiv_q   <= 1'b0;
         resNeg_q  <= 1'b0;
         remNeg_q  <= 1'b0;
         divZero_q <= 1'b0;
         accHi_q   <= '0;
         accLo_q   <= '0;
         opB_q     <= '0;
         op1Raw_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         isDiv_q   <= isDiv_d;
         resNeg_q  <= resNeg_d;
         remNeg_q  <= remNeg_d;
         divZero_q <= divZero_d;
         accHi_q   <= accHi_d;
         accLo_q   <= accLo_d;
         opB_q     <= opB_d;
         op1Raw_q  <= op1Raw_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
      end
   end

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_dz   = dz_q;
   assign o_hi   = hi_q;
   assign o_lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus randomized ops,
// all compared against a plain-arithmetic HI/LO reference model.
module tb_mdu_seq;

   localparam int WIDTH = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic             i_clk;
   logic             i_rst;
   logic             i_start;
   logic [2:0]       i_op;
   logic [WIDTH-1:0] i_op1;
   logic [WIDTH-1:0] i_op2;
   logic             o_busy;
   logic             o_done;
   logic             o_dz;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;

   int checks = 0;
   int errors = 0;

   mdu_seq #(.WIDTH(WIDTH)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_start(i_start),
      .i_op   (i_op),
      .i_op1  (i_op1),
      .i_op2  (i_op2),
      .o_busy (o_busy),
      .o_done (o_done),
      .o_dz   (o_dz),
      .o_hi   (o_hi),
      .o_lo   (o_lo)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Architectural meaning of each op in plain integer arithmetic.
   function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eHi, output logic [31:0] eLo, output logic eDz);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      eDz = 1'b0;
      eHi = '0;
      eLo = '0;
      case (op)
         OP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = sp;
            eHi = up[63:32];
            eLo = up[31:0];
         end
         OP_MULTU: begin
            up = 64'(a) * 64'(b);
            eHi = up[63:32];
            eLo = up[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (b == 32'd0) begin
               eLo = 32'hFFFF_FFFF;
               eHi = a;
               eDz = 1'b1;
            end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               eLo = 32'h8000_0000;
               eHi = 32'd0;
            end else if (op == OP_DIV) begin
               sa = a;
               sb = b;
               eLo = sa / sb;
               eHi = sa % sb;
            end else begin
               eLo = a / b;
               eHi = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = op;
      i_op1   = a;
      i_op2   = b;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_op1   = $urandom;
      i_op2   = $urandom;
      checkOutput("busyAtAccept", 64'(o_busy), 64'd1);
      checkOutput("dzClearAtAccept", 64'(o_dz), 64'd0);
   endtask

   task automatic awaitDone(input int expCycles);
      int cycles;
      bit seen;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < 40) begin
         @(posedge i_clk);
         #1;
         cycles++;
         if (o_done) seen = 1'b1;
      end
      checkOutput("doneLatency", 64'(cycles), 64'(expCycles));
      checkOutput("busyInDoneCycle", 64'(o_busy), 64'd0);
   endtask

   task automatic checkResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eHi, eLo;
      logic        eDz;
      refModel(op, a, b, eHi, eLo, eDz);
      checkOutput("hi", 64'(o_hi), 64'(eHi));
      checkOutput("lo", 64'(o_lo), 64'(eLo));
      checkOutput("dz", 64'(o_dz), 64'(eDz));
   endtask

   task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      applyStimulus(op, a, b);
      awaitDone(WIDTH + 1);
      checkResult(op, a, b);
   endtask

   // Move-to or ignored op: one cycle, never raises busy or done.
   task automatic writeHiLo(input logic [2:0] op, input logic [31:0] data,
                            input logic [31:0] expHi, input logic [31:0] expLo);
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = op;
      i_op1   = data;
      i_op2   = 32'd0;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      checkOutput("moveHi", 64'(o_hi), 64'(expHi));
      checkOutput("moveLo", 64'(o_lo), 64'(expLo));
      checkOutput("moveNoBusy", 64'(o_busy), 64'd0);
      checkOutput("moveNoDone", 64'(o_done), 64'd0);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [31:0] hiBefore, loBefore;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bit          sawDone;

      i_rst   = 1'b1;
      i_start = 1'b0;
      i_op    = 3'b000;
      i_op1   = '0;
      i_op2   = '0;
      #12;
      checkOutput("resetHi", 64'(o_hi), 64'd0);
      checkOutput("resetLo", 64'(o_lo), 64'd0);
      checkOutput("resetBusy", 64'(o_busy), 64'd0);
      checkOutput("resetDone", 64'(o_done), 64'd0);
      checkOutput("resetDz", 64'(o_dz), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      runOp(OP_MULT, 32'hFFFF_FFFD, 32'd7);
      checkOutput("mult3x7Lo", 64'(o_lo), 64'h0000_0000_FFFF_FFEB);
      runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("multuMaxHi", 64'(o_hi), 64'h0000_0000_FFFF_FFFE);
      runOp(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      checkOutput("divNeg7Lo", 64'(o_lo), 64'h0000_0000_FFFF_FFFD);
      runOp(OP_DIVU, 32'd100, 32'd7);
      runOp(OP_DIVU, 32'd7, 32'd0);
      checkOutput("divZeroFlag", 64'(o_dz), 64'd1);
      runOp(OP_DIV, 32'hFFFF_FFFB, 32'd0);
      runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp(OP_MULT, 32'd5, 32'd6);

      // A second start during CALC must be dropped, and operand changes must not leak in.
      hiBefore = o_hi;
      applyStimulus(OP_MULT, 32'd12345, 32'hFFFF_FF00);
      repeat (5) @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = OP_MTHI;
      i_op1   = 32'h55;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      checkOutput("mthiIgnoredInCalc", 64'(o_hi), 64'(hiBefore));
      awaitDone(WIDTH + 1 - 6);
      checkResult(OP_MULT, 32'd12345, 32'hFFFF_FF00);
      hiBefore = o_hi;
      writeHiLo(OP_MTLO, 32'h1234, hiBefore, 32'h0000_1234);
      writeHiLo(OP_MTHI, 32'hCAFE_0001, 32'hCAFE_0001, 32'h0000_1234);
      writeHiLo(3'b110, 32'hDEAD_BEEF, 32'hCAFE_0001, 32'h0000_1234);
      writeHiLo(3'b111, 32'hDEAD_BEEF, 32'hCAFE_0001, 32'h0000_1234);

      // Asynchronous abort in the middle of a divide.
      applyStimulus(OP_DIV, 32'd1000, 32'd7);
      repeat (10) @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      checkOutput("abortHi", 64'(o_hi), 64'd0);
      checkOutput("abortLo", 64'(o_lo), 64'd0);
      checkOutput("abortBusy", 64'(o_busy), 64'd0);
      checkOutput("abortDz", 64'(o_dz), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      sawDone = 1'b0;
      repeat (WIDTH + 5) begin
         @(posedge i_clk);
         #1;
         if (o_done) sawDone = 1'b1;
      end
      checkOutput("noDoneAfterAbort", 64'(sawDone), 64'd0);
      runOp(OP_MULT, 32'd2, 32'd3);

      for (int n = 0; n < 30; n++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = pickOperand();
         rb  = pickOperand();
         runOp(rop, ra, rb);
      end

      loBefore = o_lo;
      writeHiLo(OP_MTHI, 32'h0BAD_F00D, 32'h0BAD_F00D, loBefore);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
